// File: rtl/adc_capture_pkg.sv
// Shared constants for the ADC capture engine: FSM encoding, gpio field layout
// and a counter-width helper.
package adc_capture_pkg;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCapture = 2'd1;
  localparam logic [1:0] StDrain   = 2'd2;

  localparam int unsigned DECIM_LSB = 0;
  localparam int unsigned DECIM_W   = 4;

  // Width of a counter holding 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_beat_fifo.sv
// Show-ahead synchronous FIFO for captured ADC beats; rdata is the current head.
module adc_beat_fifo
  import adc_capture_pkg::*;
#(
  parameter int unsigned WIDTH = 129,
  parameter int unsigned DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [WIDTH-1:0]              wdata,
  input  logic                          pop,
  output logic [WIDTH-1:0]              rdata,
  output logic                          full,
  output logic                          empty,
  output logic [cnt_width(DEPTH):0]     count
);

  localparam int unsigned AW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  always_comb begin
    count   = wr_ptr_q - rd_ptr_q;
    empty   = (count == '0);
    full    = (count == (AW+1)'(DEPTH));
    do_pop  = pop && !empty;
    // A full FIFO still accepts a write in the cycle its head is popped.
    do_push = push && (!full || do_pop);
    rdata   = mem[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Multi-channel ADC capture engine: trigger-armed, decimating capture into a beat FIFO,
// streamed LSB-first at PS width with TLAST on the last stored beat.
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int unsigned N_CH          = 2,
  parameter int unsigned IN_W          = 128,
  parameter int unsigned OUT_W         = 32,
  parameter int unsigned CAPTURE_BEATS = 8,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned TRIG_BIT      = 15,
  parameter int unsigned SEL_W         = 2
) (
  input  logic                   pl_clk,
  input  logic                   rst,
  input  logic [15:0]            gpio_ctrl,
  input  logic [SEL_W-1:0]       select_in,
  input  logic [N_CH*IN_W-1:0]   s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [OUT_W-1:0]       m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   busy,
  output logic                   overflow,
  output logic                   done
);

  localparam int unsigned RATIO  = IN_W / OUT_W;
  localparam int unsigned WORD_W = cnt_width(RATIO);
  localparam int unsigned BEAT_W = cnt_width(CAPTURE_BEATS);
  localparam int unsigned CH_W   = cnt_width(N_CH);
  localparam int unsigned CNT_W  = cnt_width(FIFO_DEPTH) + 1;

  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(RATIO - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(CAPTURE_BEATS - 1);

  logic [N_CH*IN_W-1:0] adc_data_q;
  logic                 adc_valid_q;
  logic                 trig_q;
  logic [1:0]           state_q, state_d;
  logic [CH_W-1:0]      chan_q, chan_sel;
  logic [DECIM_W-1:0]   decim_q, dec_cnt_q;
  logic [BEAT_W-1:0]    beat_cnt_q;
  logic                 overflow_q, drop_last_q, done_q;
  logic [WORD_W-1:0]    word_q;

  logic                 start, keep, push, drop, final_kept, pop;
  logic [IN_W-1:0]      adc_beat;
  logic [OUT_W-1:0]     head_word;
  logic [IN_W:0]        fifo_rdata;
  logic                 fifo_full, fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic                 unused_gpio;

  assign unused_gpio = ^gpio_ctrl;

  always_comb begin
    chan_sel = '0;
    if (32'(select_in) < N_CH) chan_sel = CH_W'(select_in);

    adc_beat = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (chan_q == CH_W'(c)) adc_beat = adc_data_q[c*IN_W +: IN_W];
    end

    head_word = '0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (word_q == WORD_W'(k)) head_word = fifo_rdata[k*OUT_W +: OUT_W];
    end
  end

  always_comb begin
    m_axis_tvalid = !fifo_empty;
    pop           = m_axis_tvalid && m_axis_tready && (word_q == LAST_WORD);
    start         = (state_q == StIdle) && gpio_ctrl[TRIG_BIT] && !trig_q;
    keep          = (state_q == StCapture) && adc_valid_q && (dec_cnt_q == '0);
    push          = keep && (!fifo_full || pop);
    drop          = keep && !push;
    final_kept    = keep && (beat_cnt_q == LAST_BEAT);

    state_d = state_q;
    case (state_q)
      StIdle:    if (start) state_d = StCapture;
      StCapture: if (final_kept) state_d = StDrain;
      StDrain:   if (fifo_empty) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  adc_beat_fifo #(
    .WIDTH (IN_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (pl_clk),
    .rst_n (rst),
    .push  (push),
    .wdata ({final_kept, adc_beat}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge pl_clk or negedge rst) begin
    if (!rst) begin
      adc_data_q  <= '0;
      adc_valid_q <= 1'b0;
      trig_q      <= 1'b0;
      state_q     <= StIdle;
      chan_q      <= '0;
      decim_q     <= '0;
      dec_cnt_q   <= '0;
      beat_cnt_q  <= '0;
      overflow_q  <= 1'b0;
      drop_last_q <= 1'b0;
      done_q      <= 1'b0;
      word_q      <= '0;
    end else begin
      adc_data_q  <= s_axis_tdata;
      adc_valid_q <= s_axis_tvalid;
      trig_q      <= gpio_ctrl[TRIG_BIT];
      state_q     <= state_d;
      done_q      <= (state_q == StDrain) && fifo_empty;

      if (start) begin
        chan_q      <= chan_sel;
        decim_q     <= gpio_ctrl[DECIM_LSB +: DECIM_W];
        dec_cnt_q   <= '0;
        beat_cnt_q  <= '0;
        overflow_q  <= 1'b0;
        drop_last_q <= 1'b0;
      end

      if ((state_q == StCapture) && adc_valid_q) begin
        dec_cnt_q <= (dec_cnt_q == decim_q) ? '0 : dec_cnt_q + DECIM_W'(1);
      end
      if (keep) beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
      if (drop) overflow_q <= 1'b1;
      // Final kept beat lost to a full FIFO: the current tail must carry TLAST instead.
      if (drop && final_kept) drop_last_q <= 1'b1;

      if (m_axis_tvalid && m_axis_tready) begin
        word_q <= (word_q == LAST_WORD) ? '0 : word_q + WORD_W'(1);
      end
    end
  end

  always_comb begin
    s_axis_tready = 1'b1;
    m_axis_tdata  = m_axis_tvalid ? head_word : '0;
    m_axis_tlast  = m_axis_tvalid && (word_q == LAST_WORD) &&
                    (fifo_rdata[IN_W] || (drop_last_q && (fifo_count == CNT_W'(1))));
    busy          = (state_q != StIdle);
    overflow      = overflow_q;
    done          = done_q;
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl: a default instance and a long-capture
// instance (20 beats into a 16-deep FIFO) share the ADC/gpio stimulus.
module tb_adc_capture_ctrl;

  localparam int N_CH    = 2;
  localparam int IN_W    = 128;
  localparam int OUT_W   = 32;
  localparam int RATIO   = IN_W / OUT_W;
  localparam int DEPTH   = 16;
  localparam int BEATS_A = 8;
  localparam int BEATS_B = 20;
  localparam int DW      = N_CH * IN_W;

  logic             pl_clk = 1'b0;
  logic             rst = 1'b0;
  logic [15:0]      gpio_ctrl = '0;
  logic [1:0]       select_in = '0;
  logic [DW-1:0]    s_axis_tdata = '0;
  logic             s_axis_tvalid = 1'b0;
  logic             s_tready_a, s_tready_b;
  logic [OUT_W-1:0] tdata_a, tdata_b;
  logic             tvalid_a, tvalid_b, tlast_a, tlast_b;
  logic             tready_a = 1'b1, tready_b = 1'b1;
  logic             busy_a, busy_b, ovf_a, ovf_b, done_a, done_b;

  adc_capture_ctrl dut_a (
    .pl_clk(pl_clk), .rst(rst), .gpio_ctrl(gpio_ctrl), .select_in(select_in),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_tready_a),
    .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a), .m_axis_tready(tready_a),
    .m_axis_tlast(tlast_a), .busy(busy_a), .overflow(ovf_a), .done(done_a)
  );

  adc_capture_ctrl #(.CAPTURE_BEATS(BEATS_B), .FIFO_DEPTH(DEPTH)) dut_b (
    .pl_clk(pl_clk), .rst(rst), .gpio_ctrl(gpio_ctrl), .select_in(select_in),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_tready_b),
    .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b), .m_axis_tready(tready_b),
    .m_axis_tlast(tlast_b), .busy(busy_b), .overflow(ovf_b), .done(done_b)
  );

  always #5 pl_clk = ~pl_clk;

  int n_cmp = 0, n_fail = 0;
  longint cyc = 0;
  longint log_cyc[$];
  logic [DW-1:0] log_dat[$];
  int valid_pct = 100;
  bit rand_rdy_a = 1'b0, rdy_fix_a = 1'b1, rdy_fix_b = 1'b1;
  logic [OUT_W-1:0] got_a[$], got_b[$], exp_d[$];
  bit gotl_a[$], gotl_b[$], exp_l[$];
  int done_cnt_a = 0, done_cnt_b = 0, stall_err = 0;
  bit prev_stall = 1'b0;
  logic [OUT_W-1:0] prev_data = '0;

  // Every ADC beat offered to the DUTs, tagged with the clock edge that samples it.
  always @(posedge pl_clk) begin
    cyc++;
    if (s_axis_tvalid === 1'b1) begin
      log_cyc.push_back(cyc);
      log_dat.push_back(s_axis_tdata);
    end
  end

  // Drive next-cycle inputs, then record the handshakes those inputs will complete.
  always @(negedge pl_clk) begin
    s_axis_tvalid = ($urandom_range(99) < valid_pct);
    for (int i = 0; i < DW / 32; i++) s_axis_tdata[i*32 +: 32] = $urandom;
    tready_a = rand_rdy_a ? 1'($urandom_range(1)) : rdy_fix_a;
    tready_b = rdy_fix_b;
    if (prev_stall && (tvalid_a !== 1'b1 || tdata_a !== prev_data)) stall_err++;
    prev_stall = tvalid_a && !tready_a;
    prev_data  = tdata_a;
    if (tvalid_a && tready_a) begin got_a.push_back(tdata_a); gotl_a.push_back(tlast_a); end
    if (tvalid_b && tready_b) begin got_b.push_back(tdata_b); gotl_b.push_back(tlast_b); end
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
  end

  // Expected stream: every (decim+1)-th valid beat from the trigger edge on, up to
  // 'beats' kept; only the first 'max_store' kept beats reach the output.
  function automatic void build_exp(input longint tcyc, input int decim, input int sel,
                                    input int beats, input int max_store);
    int n = 0, kept = 0, stored = 0, ch;
    logic [IN_W-1:0] beat;
    ch = (sel < N_CH) ? sel : 0;
    exp_d.delete();
    exp_l.delete();
    foreach (log_cyc[i]) begin
      if (log_cyc[i] >= tcyc && kept < beats) begin
        if (n % (decim + 1) == 0) begin
          kept++;
          if (stored < max_store) begin
            stored++;
            beat = log_dat[i][ch*IN_W +: IN_W];
            for (int k = 0; k < RATIO; k++) begin
              exp_d.push_back(beat[k*OUT_W +: OUT_W]);
              exp_l.push_back(1'b0);
            end
          end
        end
        n++;
      end
    end
    if (exp_l.size() > 0) exp_l[exp_l.size()-1] = 1'b1;
  endfunction

  function automatic int first_bad(input bit use_b);
    int n;
    n = use_b ? got_b.size() : got_a.size();
    if (exp_d.size() < n) n = exp_d.size();
    for (int i = 0; i < n; i++) begin
      logic [OUT_W-1:0] d;
      bit l;
      d = use_b ? got_b[i] : got_a[i];
      l = use_b ? gotl_b[i] : gotl_a[i];
      if (d !== exp_d[i] || l !== exp_l[i]) return i;
    end
    return -1;
  endfunction

  task automatic trigger(input int decim, input int sel, output longint tcyc);
    @(negedge pl_clk);
    gpio_ctrl[15] = 1'b0;
    @(negedge pl_clk);
    gpio_ctrl[15]  = 1'b1;
    gpio_ctrl[3:0] = 4'(decim);
    select_in      = 2'(sel);
    tcyc           = cyc + 1;
    @(negedge pl_clk);
  endtask

  task automatic wait_done(input bit use_b, input int bound, output bit ok);
    int start;
    ok = 1'b0;
    start = use_b ? done_cnt_b : done_cnt_a;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge pl_clk);
      if ((use_b ? done_cnt_b : done_cnt_a) != start) ok = 1'b1;
    end
    repeat (2) @(negedge pl_clk);
  endtask

  task automatic wait_idle;
    int i;
    for (i = 0; i < 2000 && (busy_a || busy_b); i++) @(negedge pl_clk);
    n_cmp++;
    if (busy_a || busy_b) begin
      n_fail++;
      $display("FAIL idle_timeout: busy_a=%0b busy_b=%0b, required 0 0", busy_a, busy_b);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge pl_clk);
    n_cmp++;
    if ({tvalid_a, tlast_a, busy_a, ovf_a, done_a} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 00000",
               {tvalid_a, tlast_a, busy_a, ovf_a, done_a});
    end
    n_cmp++;
    if (tdata_a !== '0) begin
      n_fail++;
      $display("FAIL reset_tdata: got %h, required 0", tdata_a);
    end
    n_cmp++;
    if (s_tready_a !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_s_tready: got %b, required 1", s_tready_a);
    end
    @(negedge pl_clk);
    rst = 1'b1;
    repeat (2) @(negedge pl_clk);
  endtask

  task automatic test_capture(input string name, input int decim, input int sel);
    longint t;
    bit ok;
    int d0, bad;
    wait_idle();
    got_a.delete(); gotl_a.delete();
    d0 = done_cnt_a;
    trigger(decim, sel, t);
    gpio_ctrl[15] = 1'b0;
    wait_done(1'b0, 1000, ok);
    build_exp(t, decim, sel, BEATS_A, 1000);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL %s_done: no done pulse, required one", name); end
    n_cmp++;
    if (got_a.size() != exp_d.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d words, required %0d", name, got_a.size(), exp_d.size());
    end
    bad = first_bad(1'b0);
    n_cmp++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s_word[%0d]: got %h/last %0b, required %h/last %0b", name, bad,
               got_a[bad], gotl_a[bad], exp_d[bad], exp_l[bad]);
    end
    n_cmp++;
    if (ovf_a !== 1'b0 || done_cnt_a - d0 != 1) begin
      n_fail++;
      $display("FAIL %s_status: overflow=%b dones=%0d, required 0 1", name, ovf_a,
               done_cnt_a - d0);
    end
  endtask

  task automatic test_overflow;
    longint t;
    bit ok;
    int bad;
    wait_idle();
    rdy_fix_b = 1'b0;
    got_b.delete(); gotl_b.delete();
    trigger(0, 1, t);
    gpio_ctrl[15] = 1'b0;
    repeat (40) @(negedge pl_clk);
    n_cmp++;
    if ({busy_b, ovf_b, tvalid_b} !== 3'b111) begin
      n_fail++;
      $display("FAIL ovf_stalled: busy/overflow/tvalid=%b, required 111", {busy_b, ovf_b, tvalid_b});
    end
    rdy_fix_b = 1'b1;
    wait_done(1'b1, 500, ok);
    build_exp(t, 0, 1, BEATS_B, DEPTH);
    n_cmp++;
    if (!ok || got_b.size() != exp_d.size()) begin
      n_fail++;
      $display("FAIL ovf_count: done=%0b words=%0d, required 1 %0d", ok, got_b.size(), exp_d.size());
    end
    bad = first_bad(1'b1);
    n_cmp++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL ovf_word[%0d]: got %h/last %0b, required %h/last %0b", bad,
               got_b[bad], gotl_b[bad], exp_d[bad], exp_l[bad]);
    end
    n_cmp++;
    if (ovf_b !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: got %b, required 1", ovf_b);
    end
    wait_idle();
    trigger(0, 0, t);
    gpio_ctrl[15] = 1'b0;
    n_cmp++;
    if (ovf_b !== 1'b0 || busy_b !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_clear: overflow=%b busy=%b, required 0 1", ovf_b, busy_b);
    end
    wait_done(1'b1, 500, ok);
  endtask

  task automatic test_random_ready;
    rand_rdy_a = 1'b1;
    valid_pct = 60;
    stall_err = 0;
    for (int i = 0; i < 3; i++) begin
      test_capture("rand", $urandom_range(2), $urandom_range(3));
    end
    n_cmp++;
    if (stall_err != 0) begin
      n_fail++;
      $display("FAIL rand_stall: %0d unstable stalled cycles, required 0", stall_err);
    end
    rand_rdy_a = 1'b0;
    valid_pct = 100;
  endtask

  task automatic test_retrigger;
    longint t;
    bit ok;
    int d0, bad;
    wait_idle();
    got_a.delete(); gotl_a.delete();
    d0 = done_cnt_a;
    trigger(3, 1, t);
    gpio_ctrl[15] = 1'b0;
    repeat (6) @(negedge pl_clk);
    n_cmp++;
    if (busy_a !== 1'b1) begin n_fail++; $display("FAIL retrig_busy: got %b, required 1", busy_a); end
    gpio_ctrl[15]  = 1'b1;
    gpio_ctrl[3:0] = 4'd0;
    select_in      = 2'd0;
    wait_done(1'b0, 1000, ok);
    build_exp(t, 3, 1, BEATS_A, 1000);
    bad = first_bad(1'b0);
    n_cmp++;
    if (!ok || bad >= 0 || got_a.size() != exp_d.size()) begin
      n_fail++;
      $display("FAIL retrig_stream: done=%0b first_bad=%0d words=%0d, required 1 -1 %0d",
               ok, bad, got_a.size(), exp_d.size());
    end
    repeat (30) @(negedge pl_clk);
    n_cmp++;
    if (busy_a !== 1'b0 || done_cnt_a - d0 != 1) begin
      n_fail++;
      $display("FAIL retrig_single: busy=%b dones=%0d, required 0 1", busy_a, done_cnt_a - d0);
    end
    gpio_ctrl[15] = 1'b0;
  endtask

  task automatic test_reset_drain;
    longint t;
    wait_idle();
    rdy_fix_a = 1'b0;
    trigger(0, 0, t);
    gpio_ctrl[15] = 1'b0;
    repeat (20) @(negedge pl_clk);
    n_cmp++;
    if (busy_a !== 1'b1 || tvalid_a !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_pre: busy=%b tvalid=%b, required 1 1", busy_a, tvalid_a);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({tvalid_a, tlast_a, busy_a, ovf_a, done_a} !== 5'b0 || tdata_a !== '0) begin
      n_fail++;
      $display("FAIL drain_reset: flags=%b tdata=%h, required 00000 0",
               {tvalid_a, tlast_a, busy_a, ovf_a, done_a}, tdata_a);
    end
    @(negedge pl_clk);
    rst = 1'b1;
    rdy_fix_a = 1'b1;
    repeat (2) @(negedge pl_clk);
    n_cmp++;
    if (tvalid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_fifo_empty: tvalid=%b, required 0", tvalid_a);
    end
    test_capture("post_reset", 1, 1);
  endtask

  initial begin
    test_reset();
    test_capture("basic", 0, 1);
    test_capture("decim", 3, 0);
    test_overflow();
    test_random_ready();
    test_retrigger();
    test_reset_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
